// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl_pkg
//  Description : Shared widths, defaults, types and the RAW-hazard helper
//                used by the pipeline stall/bubble controller.
//                Contents:
//                  T_W / GRF_W           - Tnew/Tuse width, register index width
//                  MULT/DIV_CYCLES_DEF   - default mult/div busy lengths
//                  md_op_e               - mult vs. div selector
//                  grf_wr_t              - one downstream stage's GRF writer info
//                  raw_hazard()          - one writer-vs-source stall term
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_stall_ctrl_pkg;

    localparam int T_W             = 4;
    localparam int GRF_W           = 5;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_OP_MULT = 1'b0,
        MD_OP_DIV  = 1'b1
    } md_op_e;

    typedef struct packed {
        logic             write;
        logic [GRF_W-1:0] a3;
        logic [T_W-1:0]   tnew;
    } grf_wr_t;

    // A source operand must wait when a downstream writer targets it and the
    // value will not exist by the time the D-stage instruction consumes it.
    // Register 0 is hard-wired to zero, so it never causes a stall.
    function automatic logic raw_hazard(
        input grf_wr_t          wr,
        input logic [GRF_W-1:0] src,
        input logic [T_W-1:0]   tuse
    );
        return wr.write && (wr.a3 == src) && (src != '0) && (tuse < wr.tnew);
    endfunction

endpackage : pipe_stall_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_stall_ctrl_md_busy_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_cnt
//  Description : Multiply/divide busy counter. Loads the operation length
//                when a start is accepted, counts down while busy, pulses
//                done_o for one cycle on the 1->0 step and records a sticky
//                error when a start arrives while the unit is still busy.
//  Ports       : clk       - rising-edge clock
//                rst_n_i   - asynchronous active-low reset
//                freeze_i  - global hold; counter holds, start ignored
//                start_i   - E-stage mult/div start request
//                is_div_i  - 1 = div/divu, 0 = mult/multu
//                busy_o    - counter non-zero
//                done_o    - one-cycle pulse when the result becomes valid
//                err_o     - sticky start-while-busy flag
//  Revision    : 1.0 - initial release
// ============================================================================
module md_busy_cnt
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic freeze_i,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o,
    output logic done_o,
    output logic err_o
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_q;
    logic             done_d;
    logic             err_q;
    logic             err_d;
    logic             busy;
    md_op_e           op;

    assign busy = (cnt_q != '0);
    assign op   = md_op_e'(is_div_i);

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        err_d  = err_q;
        if (!freeze_i) begin
            if (start_i && !busy) begin
                cnt_d = (op == MD_OP_DIV) ? DIV_LOAD : MULT_LOAD;
            end else if (busy) begin
                cnt_d = cnt_q - CNT_ONE;
            end
            // cnt_q==1 implies busy, so a start in this cycle is ignored and
            // the counter reaches zero on this edge.
            done_d = (cnt_q == CNT_ONE);
            err_d  = err_q | (start_i & busy);
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign busy_o = busy;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule : md_busy_cnt
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl
//  Description : Stall/bubble controller for the 5-stage pipeline. Detects
//                D-stage RAW hazards against the E and M stage writers,
//                detects HI/LO use while the mult/div unit is busy, drives
//                the PC / F-D / E-M enables and the D-E bubble clear, and
//                keeps a saturating count of stalled cycles.
//  Ports       : clk, reset          - clock, async active-low reset
//                freeze              - whole pipeline held this cycle
//                D_rs/rt_addr, _Tuse - D-stage source indices and Tuse
//                D_is_md             - D-stage instruction touches HI/LO
//                E_/M_GRF_write/A3/Tnew - downstream writer info
//                E_md_start/_is_div  - E-stage mult/div start
//                F_PC_EN, F_D_REG_EN, D_E_REG_CLR, E_M_REG_EN - pipe control
//                stall, md_busy, md_done, md_err, stall_cnt   - status
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic [GRF_W-1:0]  D_rs_addr,
    input  logic [GRF_W-1:0]  D_rt_addr,
    input  logic [T_W-1:0]    D_rs_Tuse,
    input  logic [T_W-1:0]    D_rt_Tuse,
    input  logic              D_is_md,
    input  logic              E_GRF_write,
    input  logic [GRF_W-1:0]  E_GRF_A3,
    input  logic [T_W-1:0]    E_Tnew,
    input  logic              M_GRF_write,
    input  logic [GRF_W-1:0]  M_GRF_A3,
    input  logic [T_W-1:0]    M_Tnew,
    input  logic              E_md_start,
    input  logic              E_md_is_div,
    output logic              F_PC_EN,
    output logic              F_D_REG_EN,
    output logic              D_E_REG_CLR,
    output logic              E_M_REG_EN,
    output logic              stall,
    output logic              md_busy,
    output logic              md_done,
    output logic              md_err,
    output logic [PERF_W-1:0] stall_cnt
);

    grf_wr_t           e_wr;
    grf_wr_t           m_wr;
    logic              haz_e_rs;
    logic              haz_e_rt;
    logic              haz_m_rs;
    logic              haz_m_rt;
    logic              haz_md;
    logic              stall_w;
    logic              md_busy_w;
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] stall_cnt_d;

    // ------------------------------------------------------------------
    // Mult/div busy tracking. The start is accepted even when D is being
    // stalled: the E-stage instruction still advances.
    // ------------------------------------------------------------------
    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_cnt (
        .clk      (clk),
        .rst_n_i  (reset),
        .freeze_i (freeze),
        .start_i  (E_md_start),
        .is_div_i (E_md_is_div),
        .busy_o   (md_busy_w),
        .done_o   (md_done),
        .err_o    (md_err)
    );

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        e_wr       = '0;
        e_wr.write = E_GRF_write;
        e_wr.a3    = E_GRF_A3;
        e_wr.tnew  = E_Tnew;
        m_wr       = '0;
        m_wr.write = M_GRF_write;
        m_wr.a3    = M_GRF_A3;
        m_wr.tnew  = M_Tnew;
    end

    assign haz_e_rs = raw_hazard(e_wr, D_rs_addr, D_rs_Tuse);
    assign haz_e_rt = raw_hazard(e_wr, D_rt_addr, D_rt_Tuse);
    assign haz_m_rs = raw_hazard(m_wr, D_rs_addr, D_rs_Tuse);
    assign haz_m_rt = raw_hazard(m_wr, D_rt_addr, D_rt_Tuse);

    // A start in E this cycle will make the unit busy next cycle, so a HI/LO
    // access in D must already wait.
    assign haz_md  = D_is_md & (md_busy_w | E_md_start);
    assign stall_w = haz_e_rs | haz_e_rt | haz_m_rs | haz_m_rt | haz_md;

    // ------------------------------------------------------------------
    // Pipeline enables; freeze overrides everything, including the bubble.
    // ------------------------------------------------------------------
    always_comb begin
        F_PC_EN     = 1'b0;
        F_D_REG_EN  = 1'b0;
        D_E_REG_CLR = 1'b0;
        E_M_REG_EN  = 1'b0;
        if (!freeze) begin
            F_PC_EN     = ~stall_w;
            F_D_REG_EN  = ~stall_w;
            D_E_REG_CLR = stall_w;
            E_M_REG_EN  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!freeze && stall_w && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall     = stall_w;
    assign md_busy   = md_busy_w;
    assign stall_cnt = stall_cnt_q;

endmodule : pipe_stall_ctrl
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stall_ctrl
//  Description : Self-checking bench for pipe_stall_ctrl (PERF_W=4 build)
//                with a cycle-level reference model, directed scenarios and
//                randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    localparam int PERF_W = 4;
    localparam int SAT    = (1 << PERF_W) - 1;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic              clk;
    logic              reset;
    logic              freeze;
    logic [4:0]        D_rs_addr, D_rt_addr;
    logic [3:0]        D_rs_Tuse, D_rt_Tuse;
    logic              D_is_md;
    logic              E_GRF_write, M_GRF_write;
    logic [4:0]        E_GRF_A3, M_GRF_A3;
    logic [3:0]        E_Tnew, M_Tnew;
    logic              E_md_start, E_md_is_div;
    logic              F_PC_EN, F_D_REG_EN, D_E_REG_CLR, E_M_REG_EN;
    logic              stall, md_busy, md_done, md_err;
    logic [PERF_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: cycles of mult/div work left, pending done pulse,
    // sticky error, and number of stalled cycles so far.
    int m_left = 0;
    bit m_done = 0;
    bit m_err  = 0;
    int m_scnt = 0;

    pipe_stall_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (4),
        .PERF_W      (PERF_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .freeze      (freeze),
        .D_rs_addr   (D_rs_addr),
        .D_rt_addr   (D_rt_addr),
        .D_rs_Tuse   (D_rs_Tuse),
        .D_rt_Tuse   (D_rt_Tuse),
        .D_is_md     (D_is_md),
        .E_GRF_write (E_GRF_write),
        .E_GRF_A3    (E_GRF_A3),
        .E_Tnew      (E_Tnew),
        .M_GRF_write (M_GRF_write),
        .M_GRF_A3    (M_GRF_A3),
        .M_Tnew      (M_Tnew),
        .E_md_start  (E_md_start),
        .E_md_is_div (E_md_is_div),
        .F_PC_EN     (F_PC_EN),
        .F_D_REG_EN  (F_D_REG_EN),
        .D_E_REG_CLR (D_E_REG_CLR),
        .E_M_REG_EN  (E_M_REG_EN),
        .stall       (stall),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .md_err      (md_err),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One writer/source pair: the value arrives later than it is needed.
    function automatic bit needs_wait(bit wr, int a3, int src, int tuse, int tnew);
        return wr && (a3 == src) && (src != 0) && (tuse < tnew);
    endfunction

    function automatic bit model_stall();
        bit h;
        h = needs_wait(E_GRF_write, E_GRF_A3, D_rs_addr, D_rs_Tuse, E_Tnew)
          | needs_wait(E_GRF_write, E_GRF_A3, D_rt_addr, D_rt_Tuse, E_Tnew)
          | needs_wait(M_GRF_write, M_GRF_A3, D_rs_addr, D_rs_Tuse, M_Tnew)
          | needs_wait(M_GRF_write, M_GRF_A3, D_rt_addr, D_rt_Tuse, M_Tnew);
        return h | (D_is_md && (m_left > 0 || E_md_start));
    endfunction

    task automatic set_idle();
        reset = 1'b1; freeze = 1'b0;
        D_rs_addr = '0; D_rt_addr = '0; D_rs_Tuse = '0; D_rt_Tuse = '0; D_is_md = 1'b0;
        E_GRF_write = 1'b0; E_GRF_A3 = '0; E_Tnew = '0;
        M_GRF_write = 1'b0; M_GRF_A3 = '0; M_Tnew = '0;
        E_md_start = 1'b0; E_md_is_div = 1'b0;
    endtask

    // Check all outputs against the model for the current inputs, then
    // advance the model and the DUT across one rising edge.
    task automatic step();
        bit s;
        int left_n, scnt_n;
        bit done_n, err_n;
        if (!reset) begin
            m_left = 0; m_done = 0; m_err = 0; m_scnt = 0;
        end
        #1;
        s = model_stall();
        check("stall",       stall,       s);
        check("F_PC_EN",     F_PC_EN,     !freeze && !s);
        check("F_D_REG_EN",  F_D_REG_EN,  !freeze && !s);
        check("D_E_REG_CLR", D_E_REG_CLR, !freeze && s);
        check("E_M_REG_EN",  E_M_REG_EN,  !freeze);
        check("md_busy",     md_busy,     m_left > 0);
        check("md_done",     md_done,     m_done);
        check("md_err",      md_err,      m_err);
        check("stall_cnt",   stall_cnt,   m_scnt);
        left_n = m_left; done_n = 0; err_n = m_err; scnt_n = m_scnt;
        if (reset && !freeze) begin
            if (E_md_start && m_left == 0) left_n = E_md_is_div ? DIV_N : MULT_N;
            else if (m_left > 0) begin
                left_n = m_left - 1;
                done_n = (left_n == 0);
            end
            if (E_md_start && m_left > 0) err_n = 1;
            if (s && m_scnt < SAT) scnt_n = m_scnt + 1;
        end
        @(posedge clk);
        if (reset) begin
            m_left = left_n; m_done = done_n; m_err = err_n; m_scnt = scnt_n;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    int n_st, n_dn, n_bz;
    logic [PERF_W-1:0] cnt_before;

    initial begin
        set_idle();
        reset = 1'b0;
        #1;
        check("rst_busy", md_busy, 1'b0);
        check("rst_cnt",  stall_cnt, '0);
        do_reset();

        // lw $5 in E, beq using $5 in D; then the same with $0
        E_GRF_write = 1; E_GRF_A3 = 5'd5; E_Tnew = 4'd2; D_rs_addr = 5'd5; D_rs_Tuse = 4'd0;
        #1 check("lw_stall", stall, 1'b1);
        check("lw_pc_en", F_PC_EN, 1'b0);
        step();
        D_rs_addr = 5'd0; E_GRF_A3 = 5'd0;
        #1 check("r0_stall", stall, 1'b0);
        step();

        // M-stage writer to $7 with Tnew=1
        set_idle();
        M_GRF_write = 1; M_GRF_A3 = 5'd7; M_Tnew = 4'd1; D_rt_addr = 5'd7; D_rt_Tuse = 4'd1;
        #1 check("m_tuse1", stall, 1'b0);
        step();
        D_rt_Tuse = 4'd0;
        #1 check("m_tuse0", stall, 1'b1);
        step();

        // mult followed by mfhi, then div followed by mfhi
        for (int k = 0; k < 2; k++) begin
            if (k == 0) do_reset();
            set_idle();
            E_md_start = 1; E_md_is_div = (k == 1);
            step();
            E_md_start = 0; D_is_md = 1;
            n_st = 0; n_dn = 0;
            for (int i = 0; i < 14; i++) begin
                #1;
                n_st += int'(stall);
                n_dn += int'(md_done);
                step();
            end
            check(k == 0 ? "mult_stalls" : "div_stalls", n_st, k == 0 ? MULT_N : DIV_N);
            check("md_done_pulses", n_dn, 1);
            check("md_stall_cnt", stall_cnt, k == 0 ? MULT_N : SAT);
        end

        // start while busy, then freeze with D waiting on HI/LO
        do_reset();
        E_md_start = 1; step();       // count loads 5
        E_md_start = 0; step();       // 4
        E_md_start = 1; step();       // ignored, 3, error flagged
        E_md_start = 0; D_is_md = 1;
        #1 check("md_err_set", md_err, 1'b1);
        cnt_before = stall_cnt;
        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            E_md_start = (i == 1);
            #1 check("frz_pc_en", F_PC_EN, 1'b0);
            check("frz_clr", D_E_REG_CLR, 1'b0);
            step();
        end
        E_md_start = 0;
        check("frz_scnt", stall_cnt, cnt_before);
        freeze = 0; D_is_md = 0;
        n_bz = 0;
        for (int i = 0; i < 6; i++) begin
            #1 n_bz += int'(md_busy);
            step();
        end
        check("busy_after_frz", n_bz, 3);
        check("md_err_sticky", md_err, 1'b1);

        // reset mid-count
        do_reset();
        E_md_start = 1; step();
        E_md_start = 0; D_is_md = 1; step(); step();  // count at 3
        reset = 1'b0;
        #1 check("mid_rst_busy", md_busy, 1'b0);
        check("mid_rst_scnt", stall_cnt, '0);
        step();
        set_idle();
        #1 check("post_rst_stall", stall, 1'b0);
        for (int i = 0; i < 4; i++) step();

        // saturation of the stall counter
        E_GRF_write = 1; E_GRF_A3 = 5'd3; E_Tnew = 4'd3; D_rt_addr = 5'd3; D_rt_Tuse = 4'd1;
        for (int i = 0; i < SAT + 3; i++) step();
        check("sat_cnt", stall_cnt, SAT);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 199) != 0);
            freeze      = ($urandom_range(0, 7) == 0);
            D_rs_addr   = 5'($urandom_range(0, 3));
            D_rt_addr   = 5'($urandom_range(0, 3));
            D_rs_Tuse   = 4'($urandom_range(0, 3));
            D_rt_Tuse   = 4'($urandom_range(0, 3));
            D_is_md     = ($urandom_range(0, 3) == 0);
            E_GRF_write = 1'($urandom);
            E_GRF_A3    = 5'($urandom_range(0, 3));
            E_Tnew      = 4'($urandom_range(0, 3));
            M_GRF_write = 1'($urandom);
            M_GRF_A3    = 5'($urandom_range(0, 3));
            M_Tnew      = 4'($urandom_range(0, 3));
            E_md_start  = ($urandom_range(0, 9) == 0);
            E_md_is_div = 1'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_stall_ctrl
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Stall/bubble controller for the 5-stage pipeline. It compares D-stage Tuse against E/M-stage Tnew and destination register, and it owns the multiply/divide busy counter. It drives the enables of the PC, the F/D register and the E/M register, plus the clear of the D/E register. It sits beside the pipeline registers and sequences them; it holds no datapath values.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (1..2^CNT_W-1)
DIV_CYCLES, 10, busy cycles for div/divu (1..2^CNT_W-1)
CNT_W, 4, width of md busy counter
PERF_W, 32, width of stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
freeze  in  1  global hold: whole pipeline frozen this cycle
D_rs_addr  in  5  D-stage rs index
D_rt_addr  in  5  D-stage rt index
D_rs_Tuse  in  4  cycles until D-stage instr needs rs
D_rt_Tuse  in  4  cycles until D-stage instr needs rt
D_is_md  in  1  D-stage instr touches HI/LO (mult/div/mfhi/mflo/mthi/mtlo)
E_GRF_write, E_GRF_A3, E_Tnew  in  1/5/4  E-stage writer info
M_GRF_write, M_GRF_A3, M_Tnew  in  1/5/4  M-stage writer info
E_md_start  in  1  E-stage instr starts mult/div this cycle
E_md_is_div  in  1  1 = div/divu, 0 = mult/multu (valid with E_md_start)
F_PC_EN  out  1  PC update enable
F_D_REG_EN  out  1  F/D register enable
D_E_REG_CLR  out  1  load bubble into D/E register
E_M_REG_EN  out  1  E/M register enable
stall  out  1  stall condition active
md_busy  out  1  md unit computing
md_done  out  1  one-cycle pulse when md result becomes valid
md_err  out  1  sticky: start received while busy
stall_cnt  out  PERF_W  saturating count of stall cycles

Behaviour:
- Registered state: md_cnt[CNT_W], md_err, stall_cnt, md_done. On reset low, all are cleared asynchronously. While in reset, md_busy=0, md_done=0, md_err=0, stall_cnt=0.
- Hazard terms (combinational):
  - haz_E_rs = E_GRF_write & (E_GRF_A3==D_rs_addr) & (D_rs_addr!=0) & (D_rs_Tuse < E_Tnew).
  - haz_E_rt, haz_M_rs and haz_M_rt are formed the same way from the matching rt and M-stage fields.
  - Register 0 never stalls.
- md hazard: haz_md = D_is_md & (md_busy | E_md_start).
- stall = any hazard term | haz_md.
- md_busy = (md_cnt != 0).
- Enables, with freeze=0:
  - F_PC_EN = F_D_REG_EN = ~stall.
  - D_E_REG_CLR = stall.
  - E_M_REG_EN = 1.
- Enables, with freeze=1: all enables = 0 and D_E_REG_CLR = 0, regardless of stall.
- md counter, with freeze=0:
  - If E_md_start & ~md_busy, load MULT_CYCLES or DIV_CYCLES per E_md_is_div.
  - Otherwise, if md_busy, decrement.
  - Transition 1->0 sets md_done=1 for exactly one cycle; md_done is 0 otherwise.
- E_md_start while md_busy: the start is ignored, the counter continues and md_err is set. md_err clears only on reset.
- Start accepted in the same cycle that a D-stage stall is raised: the start is accepted, because the E-stage instruction still advances.
- freeze=1: md_cnt, md_done (forced 0), stall_cnt hold; E_md_start is ignored and md_err is not set.
- stall_cnt increments on every clk edge with stall=1 and freeze=0, and saturates at all-ones (no wrap).
- Latency: stall is a same-cycle combinational function of inputs and md_cnt. A mult started at edge k gives md_busy=1 for edges k+1..k+MULT_CYCLES-1 and md_busy=0 from edge k+MULT_CYCLES. md_done is high during the cycle following edge k+MULT_CYCLES.
- Reset mid-operation: the counter aborts to 0 immediately. No md_done pulse is generated.

Decomposition:
- Shared package: Tnew/Tuse width (4), GRF index width (5), and the MULT_CYCLES/DIV_CYCLES defaults.
- One natural sub-module, md_busy_cnt: the load/decrement counter with md_busy, md_done and md_err. The hazard compare and enable logic stay in the top level.

Test Plan:
- Reset low mid-count (md_cnt=3) -> md_busy=0 at once, stall_cnt=0, md_err=0; after release, stall=0 with idle inputs.
- lw to $5 in E (E_Tnew=2), D beq with rs=5, D_rs_Tuse=0 -> stall=1, F_PC_EN=0, D_E_REG_CLR=1, E_M_REG_EN=1. Same case with rs=0 -> stall=0.
- M_GRF_A3=7, M_Tnew=1, D_rt_addr=7, D_rt_Tuse=1 -> no stall. With D_rt_Tuse=0 -> stall for 1 cycle.
- E_md_start=1, is_div=0, then D mfhi -> stall for 5 cycles; md_done pulses once; stall_cnt=5. Repeat with div -> 10 cycles.
- Second E_md_start while md_cnt=4 -> md_err=1 (sticky), counter unaffected. Then freeze=1 for 3 cycles -> md_cnt held, all enables 0, stall_cnt unchanged.
- Force stall for 2^PERF_W+2 cycles (PERF_W=4 build) -> stall_cnt sticks at 15.
